// File: rtl/tv80_bus_tracer.sv
// Passive tv80s bus-cycle tracer: classifies completed bus cycles and queues {type,addr,data}.
// Optional TV80_TRACE_TIMESTAMP_EN adds a per-entry free-running cycle timestamp on tr_ts.
module tv80_bus_tracer #(
    parameter int unsigned AW    = 16,
    parameter int unsigned DW    = 8,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned CNTW  = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            m1_n,
    input  logic            mreq_n,
    input  logic            iorq_n,
    input  logic            rd_n,
    input  logic            wr_n,
    input  logic            rfsh_n,
    input  logic [AW-1:0]   A,
    input  logic [DW-1:0]   di,
    input  logic [DW-1:0]   dout,
    input  logic [5:0]      cap_mask,
    input  logic            clr,
    output logic            tr_valid,
    input  logic            tr_ready,
    output logic [2:0]      tr_type,
    output logic [AW-1:0]   tr_addr,
    output logic [DW-1:0]   tr_data,
`ifdef TV80_TRACE_TIMESTAMP_EN
    output logic [31:0]     tr_ts,
`endif
    output logic            overflow,
    output logic [CNTW-1:0] drop_cnt,
    output logic [CNTW-1:0] evt_cnt
);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned EW = 3 + AW + DW;

    localparam logic [2:0] TyOpFetch = 3'd0;
    localparam logic [2:0] TyMemRd   = 3'd1;
    localparam logic [2:0] TyMemWr   = 3'd2;
    localparam logic [2:0] TyIoRd    = 3'd3;
    localparam logic [2:0] TyIoWr    = 3'd4;
    localparam logic [2:0] TyIntAck  = 3'd5;

    // Strobe vector order: {m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n}
    function automatic logic is_active(input logic [5:0] s);
        return ((((!s[4]) && s[0]) || (!s[3])) && ((!s[2]) || (!s[1]))) || ((!s[5]) && (!s[3]));
    endfunction

    logic [5:0]      s_strb_q, s_strb_d, cur_strb;
    logic [AW-1:0]   s_a_q, s_a_d;
    logic [DW-1:0]   s_di_q, s_di_d, s_dout_q, s_dout_d;
    logic            armed_q, armed_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW:0]     cnt_q, cnt_d;
    logic            overflow_q, overflow_d;
    logic [CNTW-1:0] drop_cnt_q, drop_cnt_d, evt_cnt_q, evt_cnt_d;
    logic [EW-1:0]   mem_q [DEPTH];
    logic [EW-1:0]   wr_entry;
    logic [7:0]      mask_ext;
    logic [2:0]      evt_type;
    logic [DW-1:0]   evt_data;
    logic            cur_act, evt_det, evt_en, full, empty, push, pop, drop;
`ifdef TV80_TRACE_TIMESTAMP_EN
    logic [31:0]     ts_q, ts_d;
    logic [31:0]     ts_mem_q [DEPTH];
`endif

    always_comb begin
        cur_strb = {m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n};
        cur_act  = is_active(cur_strb);
        s_strb_d = cur_strb;
        s_a_d    = A;
        s_di_d   = di;
        s_dout_d = dout;
        // After reset an idle sample must be seen first, so a cycle cut by reset is never traced
        armed_d  = armed_q | ~cur_act;
        evt_det  = armed_q & is_active(s_strb_q) & ~cur_act;

        if (!s_strb_q[5] && !s_strb_q[3])      evt_type = TyIntAck;
        else if (!s_strb_q[4] && !s_strb_q[2]) evt_type = s_strb_q[5] ? TyMemRd : TyOpFetch;
        else if (!s_strb_q[4] && !s_strb_q[1]) evt_type = TyMemWr;
        else if (!s_strb_q[3] && !s_strb_q[2]) evt_type = TyIoRd;
        else                                   evt_type = TyIoWr;

        evt_data = (evt_type == TyMemWr || evt_type == TyIoWr) ? s_dout_q : s_di_q;
        wr_entry = {evt_type, s_a_q, evt_data};
        mask_ext = {2'b00, cap_mask};
        evt_en   = evt_det & mask_ext[evt_type];

        full  = (cnt_q == (PW+1)'(DEPTH));
        empty = (cnt_q == '0);
        pop   = tr_ready & ~empty;
        push  = evt_en & (~full | pop);
        drop  = evt_en & full & ~pop;

        wr_ptr_d = wr_ptr_q + PW'(push);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        cnt_d    = cnt_q + (PW+1)'(push) - (PW+1)'(pop);

        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;
        evt_cnt_d  = evt_cnt_q;
        if (clr) begin
            overflow_d = 1'b0;
            drop_cnt_d = '0;
            evt_cnt_d  = '0;
        end else begin
            if (drop) begin
                overflow_d = 1'b1;
                if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + 1'b1;
            end
            if (evt_en && evt_cnt_q != '1) evt_cnt_d = evt_cnt_q + 1'b1;
        end
`ifdef TV80_TRACE_TIMESTAMP_EN
        ts_d = ts_q + 32'd1;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s_strb_q   <= '1;
            s_a_q      <= '0;
            s_di_q     <= '0;
            s_dout_q   <= '0;
            armed_q    <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
            evt_cnt_q  <= '0;
        end else begin
            s_strb_q   <= s_strb_d;
            s_a_q      <= s_a_d;
            s_di_q     <= s_di_d;
            s_dout_q   <= s_dout_d;
            armed_q    <= armed_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
            evt_cnt_q  <= evt_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && push) mem_q[wr_ptr_q] <= wr_entry;
    end

`ifdef TV80_TRACE_TIMESTAMP_EN
    always_ff @(posedge clk) begin
        if (reset) ts_q <= '0;
        else       ts_q <= ts_d;
    end

    always_ff @(posedge clk) begin
        if (!reset && push) ts_mem_q[wr_ptr_q] <= ts_q;
    end

    assign tr_ts = empty ? 32'd0 : ts_mem_q[rd_ptr_q];
`endif

    assign tr_valid = ~empty;
    assign {tr_type, tr_addr, tr_data} = empty ? {EW{1'b0}} : mem_q[rd_ptr_q];
    assign overflow = overflow_q;
    assign drop_cnt = drop_cnt_q;
    assign evt_cnt  = evt_cnt_q;
endmodule

// File: tb/tb_tv80_bus_tracer.sv
// Bench for tv80_bus_tracer: emulated tv80s bus cycles, queue-based reference model checked
// every cycle, plus hand-computed expectations for the instruction-level scenarios.
module tb_tv80_bus_tracer;
    localparam int AW = 16, DW = 8, DEPTH = 4, CNTW = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n, clr, tr_ready, tr_valid, overflow;
    logic [AW-1:0] A, tr_addr;
    logic [DW-1:0] di, dout, tr_data;
    logic [5:0] cap_mask;
    logic [2:0] tr_type;
    logic [CNTW-1:0] drop_cnt, evt_cnt;
`ifdef TV80_TRACE_TIMESTAMP_EN
    logic [31:0] tr_ts;
`endif

    tv80_bus_tracer #(.AW(AW), .DW(DW), .DEPTH(DEPTH), .CNTW(CNTW)) dut (
        .clk(clk), .reset(reset), .m1_n(m1_n), .mreq_n(mreq_n), .iorq_n(iorq_n),
        .rd_n(rd_n), .wr_n(wr_n), .rfsh_n(rfsh_n), .A(A), .di(di), .dout(dout),
        .cap_mask(cap_mask), .clr(clr), .tr_valid(tr_valid), .tr_ready(tr_ready),
        .tr_type(tr_type), .tr_addr(tr_addr), .tr_data(tr_data),
`ifdef TV80_TRACE_TIMESTAMP_EN
        .tr_ts(tr_ts),
`endif
        .overflow(overflow), .drop_cnt(drop_cnt), .evt_cnt(evt_cnt)
    );

    typedef struct {
        logic [2:0]  ty;
        logic [15:0] a;
        logic [7:0]  d;
        logic [31:0] ts;
    } ent_t;

    ent_t q[$];
    ent_t ev_e;
    bit ev_on;
    bit m_ovf;
    int m_drop, m_evt;
    logic [31:0] m_ts;
    int n_cmp, n_bad;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: FIFO as a bounded queue, counters as plain integers
    task automatic model_step();
        bit pop, en;
        ent_t e;
        if (reset) begin
            q.delete();
            m_ovf = 0; m_drop = 0; m_evt = 0; m_ts = 0;
            return;
        end
        pop = tr_ready && q.size() > 0;
        en  = ev_on && cap_mask[ev_e.ty];
        e = ev_e;
        e.ts = m_ts;
        if (pop) void'(q.pop_front());
        if (en) begin
            if (q.size() < DEPTH) q.push_back(e);
            else begin
                m_ovf = 1;
                if (m_drop < 65535) m_drop++;
            end
        end
        if (clr) begin
            m_ovf = 0; m_drop = 0; m_evt = 0;
        end else if (en && m_evt < 65535) m_evt++;
        m_ts = m_ts + 1;
    endtask

    task automatic check_all();
        chk("tr_valid", tr_valid, q.size() > 0);
        if (q.size() > 0) begin
            chk("tr_type", tr_type, q[0].ty);
            chk("tr_addr", tr_addr, q[0].a);
            chk("tr_data", tr_data, q[0].d);
`ifdef TV80_TRACE_TIMESTAMP_EN
            chk("tr_ts", tr_ts, q[0].ts);
`endif
        end else begin
            chk("empty_head", {tr_type, tr_addr, tr_data}, 0);
        end
        chk("overflow", overflow, m_ovf);
        chk("drop_cnt", drop_cnt, m_drop);
        chk("evt_cnt", evt_cnt, m_evt);
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic strb(input logic m1, mreq, iorq, rd, wr, rf);
        m1_n = m1; mreq_n = mreq; iorq_n = iorq; rd_n = rd; wr_n = wr; rfsh_n = rf;
    endtask

    // One bus cycle of the given type; optional pop request on its completion edge
    task automatic bus(input logic [2:0] ty, input logic [15:0] a, input logic [7:0] d,
                       input bit pop_end);
        A = a;
        di   = (ty == 3'd2 || ty == 3'd4) ? ~d : d;
        dout = (ty == 3'd2 || ty == 3'd4) ? d : ~d;
        case (ty)
            3'd0:    strb(0, 0, 1, 0, 1, 1);
            3'd1:    strb(1, 0, 1, 0, 1, 1);
            3'd2:    strb(1, 0, 1, 1, 0, 1);
            3'd3:    strb(1, 1, 0, 0, 1, 1);
            3'd4:    strb(1, 1, 0, 1, 0, 1);
            default: strb(0, 1, 0, 1, 1, 1);
        endcase
        cyc();
        cyc();
        if (ty == 3'd0) begin
            A = 16'h7F00;
            strb(1, 0, 1, 1, 1, 0);
        end else strb(1, 1, 1, 1, 1, 1);
        ev_on = 1;
        ev_e.ty = ty; ev_e.a = a; ev_e.d = d; ev_e.ts = 0;
        tr_ready = pop_end;
        cyc();
        ev_on = 0;
        tr_ready = 0;
        if (ty == 3'd0) cyc();
        strb(1, 1, 1, 1, 1, 1);
    endtask

    task automatic pop_one();
        tr_ready = 1;
        cyc();
        tr_ready = 0;
    endtask

    task automatic drain();
        tr_ready = 1;
        repeat (DEPTH + 2) cyc();
        tr_ready = 0;
    endtask

    task automatic do_clr();
        clr = 1;
        cyc();
        clr = 0;
    endtask

    int e0;
`ifdef TV80_TRACE_TIMESTAMP_EN
    logic [31:0] t0;
`endif

    initial begin
        n_cmp = 0; n_bad = 0; ev_on = 0;
        m_ovf = 0; m_drop = 0; m_evt = 0; m_ts = 0;
        reset = 1; clr = 0; tr_ready = 0; cap_mask = 6'h3F;
        A = '0; di = '0; dout = '0;
        strb(1, 1, 1, 1, 1, 1);
        repeat (2) cyc();
        reset = 0;
        cyc();
        chk("rst_valid", tr_valid, 0);
        chk("rst_evt", evt_cnt, 0);

        // CB 70 at 0000
        bus(3'd0, 16'h0000, 8'hCB, 0);
        bus(3'd0, 16'h0001, 8'h70, 0);
        chk("cb_type0", tr_type, 3'd0);
        chk("cb_addr0", tr_addr, 16'h0000);
        chk("cb_data0", tr_data, 8'hCB);
        pop_one();
        chk("cb_addr1", tr_addr, 16'h0001);
        chk("cb_data1", tr_data, 8'h70);
        drain();

        // LD (1234h),A with A=5A
        bus(3'd0, 16'h0002, 8'h32, 0);
        bus(3'd1, 16'h0003, 8'h34, 0);
        bus(3'd1, 16'h0004, 8'h12, 0);
        e0 = m_evt;
        bus(3'd2, 16'h1234, 8'h5A, 0);
        chk("ld_evt_inc", evt_cnt, e0 + 1);
        repeat (3) pop_one();
        chk("ld_type", tr_type, 3'd2);
        chk("ld_addr", tr_addr, 16'h1234);
        chk("ld_data", tr_data, 8'h5A);
        drain();

        // IN A,(7Fh), io[7F]=3C
        bus(3'd0, 16'h0005, 8'hDB, 0);
        bus(3'd1, 16'h0006, 8'h7F, 0);
        bus(3'd3, 16'h5A7F, 8'h3C, 0);
        repeat (2) pop_one();
        chk("in_type", tr_type, 3'd3);
        chk("in_addr_lo", tr_addr[7:0], 8'h7F);
        chk("in_data", tr_data, 8'h3C);
        pop_one();
        chk("in_no_rfsh", tr_valid, 0);

        // Overflow with DEPTH=4, six writes, no consumer
        do_clr();
        for (int i = 0; i < 6; i++) bus(3'd2, 16'h8000 + 16'(i), 8'(8'h10 + i), 0);
        chk("ovf_flag", overflow, 1);
        chk("ovf_drop", drop_cnt, 2);
        chk("ovf_evt", evt_cnt, 6);
        chk("ovf_head", tr_addr, 16'h8000);
        do_clr();
        chk("clr_ovf", overflow, 0);
        chk("clr_drop", drop_cnt, 0);
        chk("clr_evt", evt_cnt, 0);
        chk("clr_keep", tr_valid, 1);
        drain();

        // Only MEMWR captured; then full + push + pop on the same edge
        cap_mask = 6'b000100;
        do_clr();
        bus(3'd0, 16'h0100, 8'h00, 0);
        bus(3'd1, 16'h0101, 8'h01, 0);
        bus(3'd2, 16'hA000, 8'h11, 0);
        bus(3'd4, 16'h0010, 8'h99, 0);
        bus(3'd5, 16'h0038, 8'hFF, 0);
        bus(3'd2, 16'hA001, 8'h22, 0);
        bus(3'd2, 16'hA002, 8'h33, 0);
        bus(3'd2, 16'hA003, 8'h44, 0);
        chk("mask_evt", evt_cnt, 4);
        chk("mask_head", tr_addr, 16'hA000);
        bus(3'd2, 16'hA004, 8'h55, 1);
        chk("fpp_drop", drop_cnt, 0);
        chk("fpp_ovf", overflow, 0);
        chk("fpp_evt", evt_cnt, 5);
        chk("fpp_head", tr_addr, 16'hA001);
        cap_mask = 6'h3F;
        drain();

        // Reset mid write cycle; release after reset must not be traced
        bus(3'd2, 16'hB000, 8'h77, 0);
        A = 16'hC000; dout = 8'h66;
        strb(1, 0, 1, 1, 0, 1);
        cyc();
        reset = 1;
        cyc();
        chk("midrst_valid", tr_valid, 0);
        reset = 0;
        cyc();
        strb(1, 1, 1, 1, 1, 1);
        cyc();
        cyc();
        chk("midrst_noent", tr_valid, 0);
        chk("midrst_evt", evt_cnt, 0);

`ifdef TV80_TRACE_TIMESTAMP_EN
        bus(3'd0, 16'h0200, 8'h00, 0);
        bus(3'd0, 16'h0201, 8'h00, 0);
        t0 = tr_ts;
        pop_one();
        chk("ts_m1_len", tr_ts - t0, 32'd4);
        drain();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
